fifo_enq_packer: RTL and testbench

//   Upstream feeder of the async FIFO enqueue port, entirely in the enq_clk domain.

---
 rtl/fifo_enq_packer.sv | 112 +++++++++++
 tb/tb_fifo_enq_packer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_enq_packer.sv
// Packs narrow beats into RATIO-lane words (keep mask + last flag) for the async FIFO enqueue port.
// Partial words are released on in_last or after TIMEOUT idle cycles with a partially filled word.
module fifo_enq_packer #(
    parameter int IN_W    = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  enq_clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [IN_W*RATIO-1:0] out_data,
    output logic [RATIO-1:0]      out_keep,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CW = $clog2(RATIO);
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);

    typedef enum logic {EMPTY, FILL} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [IN_W-1:0]       lanes [RATIO];
    logic [IW-1:0]         idle;

    logic                  out_free;
    logic                  accept;
    logic                  beat_emit;
    logic                  timeout_emit;
    logic                  load;
    logic [IN_W*RATIO-1:0] word;
    logic [RATIO-1:0]      word_keep;

    always_comb begin
        out_free     = !out_valid || out_ready;
        in_ready     = rst_n && out_free && !flush;
        accept       = in_valid && in_ready;
        beat_emit    = accept && (in_last || cnt == LAST_LANE);
        timeout_emit = (TIMEOUT != 0) && (state == FILL) && !accept && !flush
                       && out_free && (idle == IDLE_MAX);
        load         = beat_emit || timeout_emit;
    end

    // Lanes beyond the current fill level are forced to zero so stale data never leaks out.
    always_comb begin
        word      = '0;
        word_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (CW'(i) < cnt) begin
                word[i*IN_W +: IN_W] = lanes[i];
                word_keep[i]         = 1'b1;
            end else if (CW'(i) == cnt && beat_emit) begin
                word[i*IN_W +: IN_W] = in_data;
                word_keep[i]         = 1'b1;
            end
        end
    end

    always_ff @(posedge enq_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            cnt       <= '0;
            idle      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            for (int i = 0; i < RATIO; i++) begin
                lanes[i] <= '0;
            end
        end else if (flush) begin
            state     <= EMPTY;
            cnt       <= '0;
            idle      <= '0;
            out_valid <= 1'b0;
        end else begin
            // A load can only happen when the output register is free, so it may replace a draining word.
            if (load) begin
                out_data  <= word;
                out_keep  <= word_keep;
                out_last  <= beat_emit && in_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (load) begin
                state <= EMPTY;
                cnt   <= '0;
                idle  <= '0;
            end else if (accept) begin
                lanes[cnt] <= in_data;
                cnt        <= cnt + 1'b1;
                state      <= FILL;
                idle       <= '0;
            end else if (state == EMPTY) begin
                idle <= '0;
            end else if (idle != IDLE_MAX) begin
                idle <= idle + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_enq_packer.sv
// Scoreboard bench for fifo_enq_packer: expected words are queued as stimulus is driven
// and checked by a negedge monitor whenever the DUT hands a word over.
module tb_fifo_enq_packer;

    localparam int IN_W    = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;

    logic                  enq_clk   = 1'b0;
    logic                  rst_n     = 1'b0;
    logic                  flush     = 1'b0;
    logic [IN_W-1:0]       in_data   = '0;
    logic                  in_valid  = 1'b0;
    logic                  in_last   = 1'b0;
    logic                  in_ready;
    logic [IN_W*RATIO-1:0] out_data;
    logic [RATIO-1:0]      out_keep;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready = 1'b0;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [36:0] exp_q[$];
    logic        held = 1'b0;
    logic [36:0] held_word = '0;

    always #5 enq_clk = ~enq_clk;

    fifo_enq_packer #(.IN_W(IN_W), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
        .enq_clk  (enq_clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_keep (out_keep),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Inputs only change just after posedge, so negedge sees the values the next edge will use.
    always @(negedge enq_clk) begin
        logic [36:0] exp;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                n_cmp++;
                if ({out_valid, out_last, out_keep, out_data} !== {1'b1, held_word}) begin
                    n_fail++;
                    $display("[TB] FAIL hold_stable: got valid=%b word=%h, required valid=1 word=%h",
                             out_valid, {out_last, out_keep, out_data}, held_word);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_word: got %h, required no word",
                             {out_last, out_keep, out_data});
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_last, out_keep, out_data} !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL word_out: got last=%b keep=%b data=%h, required last=%b keep=%b data=%h",
                                 out_last, out_keep, out_data, exp[36], exp[35:32], exp[31:0]);
                    end
                end
            end
            held      = out_valid && !out_ready;
            held_word = {out_last, out_keep, out_data};
        end
    end

    task automatic tick();
        @(posedge enq_clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back({l, k, d});
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        bit accepted;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        #1;
        accepted = 1'b0;
        for (int n = 0; n < 200 && !accepted; n++) begin
            if (in_ready) accepted = 1'b1;
            tick();
        end
        n_cmp++;
        if (!accepted) begin
            n_fail++;
            $display("[TB] FAIL beat_accept: beat %h not accepted within 200 cycles, required acceptance", d);
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain_%s: %0d words outstanding, required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({out_valid, in_ready, out_last} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: valid/in_ready/last=%b, required 000",
                     {out_valid, in_ready, out_last});
        end
        n_cmp++;
        if ({out_keep, out_data} !== 36'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_word: keep=%b data=%h, required keep=0000 data=00000000",
                     out_keep, out_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_word();
        out_ready = 1'b1;
        push_exp(32'h44332211, 4'b1111, 1'b0);
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        idle_inputs();
        n_cmp++;
        if ({out_valid, out_keep, out_data} !== {1'b1, 4'b1111, 32'h44332211}) begin
            n_fail++;
            $display("[TB] FAIL full_latency: valid=%b keep=%b data=%h, required valid=1 keep=1111 data=44332211",
                     out_valid, out_keep, out_data);
        end
        wait_drain("full");
    endtask

    task automatic test_partial_last();
        out_ready = 1'b1;
        push_exp(32'h0000BBAA, 4'b0011, 1'b1);
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        idle_inputs();
        wait_drain("partial");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        push_exp(32'h84838281, 4'b1111, 1'b0);
        push_exp(32'h00000085, 4'b0001, 1'b1);
        for (int i = 1; i <= 4; i++) send_beat(8'h80 + 8'(i), 1'b0);
        send_beat(8'h85, 1'b1);
        idle_inputs();
        n_cmp++;
        if ({out_valid, out_data} !== {1'b1, 32'h00000085}) begin
            n_fail++;
            $display("[TB] FAIL b2b_reload: valid=%b data=%h, required valid=1 data=00000085",
                     out_valid, out_data);
        end
        wait_drain("b2b");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push_exp(32'h04030201, 4'b1111, 1'b0);
        push_exp(32'h08070605, 4'b1111, 1'b0);
        push_exp(32'h00000009, 4'b0001, 1'b1);
        for (int i = 1; i <= 4; i++) send_beat(8'(i), 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h05;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if ({in_ready, out_valid} !== 2'b01) begin
                n_fail++;
                $display("[TB] FAIL bp_hold: in_ready=%b out_valid=%b, required in_ready=0 out_valid=1",
                         in_ready, out_valid);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 5; i <= 8; i++) send_beat(8'(i), 1'b0);
        send_beat(8'h09, 1'b1);
        idle_inputs();
        wait_drain("backpressure");
    endtask

    task automatic test_timeout();
        out_ready = 1'b1;
        push_exp(32'h0000005A, 4'b0001, 1'b0);
        send_beat(8'h5A, 1'b0);
        idle_inputs();
        repeat (TIMEOUT) tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL timeout_early: out_valid=%b, required 0", out_valid);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_last, out_keep, out_data} !== {1'b1, 1'b0, 4'b0001, 32'h0000005A}) begin
            n_fail++;
            $display("[TB] FAIL timeout_emit: valid=%b last=%b keep=%b data=%h, required 1 0 0001 0000005a",
                     out_valid, out_last, out_keep, out_data);
        end
        wait_drain("timeout");

        out_ready = 1'b0;
        push_exp(32'h0000003C, 4'b0001, 1'b0);
        send_beat(8'h3C, 1'b0);
        idle_inputs();
        repeat (TIMEOUT + 8) tick();
        n_cmp++;
        if ({out_valid, out_data} !== {1'b1, 32'h0000003C}) begin
            n_fail++;
            $display("[TB] FAIL timeout_wait: valid=%b data=%h, required valid=1 data=0000003c",
                     out_valid, out_data);
        end
        n_cmp++;
        if (exp_q.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL timeout_held: %0d words outstanding, required 1", exp_q.size());
        end
        out_ready = 1'b1;
        wait_drain("timeout_wait");
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        in_data = 8'h04;
        flush   = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_ready: in_ready=%b, required 0", in_ready);
        end
        tick();
        flush = 1'b0;
        idle_inputs();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_valid: out_valid=%b, required 0", out_valid);
        end
        repeat (TIMEOUT + 4) tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_stale: out_valid=%b after idle, required 0", out_valid);
        end
        push_exp(32'h000000C3, 4'b0001, 1'b1);
        send_beat(8'hC3, 1'b1);
        idle_inputs();
        wait_drain("flush");
    endtask

    task automatic test_reset_mid_packet();
        out_ready = 1'b1;
        send_beat(8'hE1, 1'b0);
        send_beat(8'hE2, 1'b0);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL midreset: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push_exp(32'hD4D3D2D1, 4'b1111, 1'b0);
        for (int i = 1; i <= 4; i++) send_beat(8'hD0 + 8'(i), 1'b0);
        idle_inputs();
        wait_drain("midreset");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_full_word();
        test_partial_last();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_flush();
        test_reset_mid_packet();
        repeat (3) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL final_queue: %0d words outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
